instr_decode_q: RTL

Parametrised successor to the single-word instruction decoder of the pseudo 8-bit microprocessor. It accepts instruction words over a valid/ready handshake and splits each into opcode, register and immediate fields. It optionally merges two-word long-immediate instructions and buffers the decoded results in an output FIFO. It sits between instruction fetch and the execute/register-file stage, so decode and execute can stall independently.

---
 rtl/instr_decode_q.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instr_decode_q.sv
// Instruction decoder with valid/ready input and output FIFO of decoded fields.
// Define DEC_EXT_EN to merge two-word long-immediate instructions (fmt 3).
module instr_decode_q #(
  parameter int REG_BITS  = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4+2*REG_BITS-1:0]        in_instr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [3:0]                     opcode,
  output logic [REG_BITS-1:0]            rd,
  output logic [REG_BITS-1:0]            rs,
  output logic [REG_BITS-1:0]            imm2,
  output logic [2*REG_BITS-1:0]          imm4,
  output logic [4+2*REG_BITS-1:0]        imm_ext,
  output logic [1:0]                     fmt,
  output logic [$clog2(OUT_DEPTH+1)-1:0] count
);

  localparam int IW = 4 + 2*REG_BITS;
  localparam int LW = 2*REG_BITS;
  localparam int CW = $clog2(OUT_DEPTH+1);
  localparam int PW = $clog2(OUT_DEPTH);

  typedef struct packed {
    logic [3:0]          op;
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] imm2;
    logic [LW-1:0]       imm4;
`ifdef DEC_EXT_EN
    logic [IW-1:0]       ext;
`endif
    logic [1:0]          fmt;
  } entry_t;

  function automatic entry_t decode(input logic [IW-1:0] w);
    entry_t e;
    logic [LW-1:0] l;
    e    = '0;
    e.op = w[IW-1:IW-4];
    l    = w[LW-1:0];
    case (e.op)
      4'h0, 4'h1: begin
        e.fmt  = 2'd0;
        e.imm4 = l;
      end
      4'h2, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: begin
        e.fmt  = 2'd1;
        e.rd   = l[LW-1:REG_BITS];
        e.imm2 = l[REG_BITS-1:0];
      end
      default: begin
        e.fmt = 2'd2;
        e.rd  = l[LW-1:REG_BITS];
        e.rs  = l[REG_BITS-1:0];
      end
    endcase
    return e;
  endfunction

  entry_t          mem [OUT_DEPTH];
  entry_t          head;
  entry_t          push_data;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count_q;
  logic            accept, pop, push;

  assign in_ready  = rst_n && !flush && (count_q < CW'(OUT_DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

`ifdef DEC_EXT_EN
  typedef enum logic {IDLE, EXT} state_t;
  state_t state, state_nxt;
  entry_t pend_q, pend_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pend_q <= '0;
    end else if (flush) begin
      state  <= IDLE;
      pend_q <= '0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
    end
  end

  // The first word of a long immediate is parked; the second completes it raw.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_q;
    push      = 1'b0;
    push_data = decode(in_instr);
    if (accept) begin
      case (state)
        IDLE: begin
          if (push_data.op[3:1] == 3'b000 && (&in_instr[LW-1:0])) begin
            pend_nxt     = push_data;
            pend_nxt.fmt = 2'd3;
            state_nxt    = EXT;
          end else begin
            push = 1'b1;
          end
        end
        EXT: begin
          push          = 1'b1;
          push_data     = pend_q;
          push_data.ext = in_instr;
          state_nxt     = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign imm_ext = head.ext;
`else
  always_comb begin
    push      = accept;
    push_data = decode(in_instr);
  end

  assign imm_ext = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_DEPTH; i++) mem[PW'(i)] <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head   = mem[rptr];
  assign opcode = head.op;
  assign rd     = head.rd;
  assign rs     = head.rs;
  assign imm2   = head.imm2;
  assign imm4   = head.imm4;
  assign fmt    = head.fmt;

endmodule
